// File: rtl/mac_pkg.sv
// Shared constants, FSM state type and lane-slicing helper for the MAC array job controller.
package mac_pkg;

  localparam int unsigned LANES  = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StHold
  } state_e;

  // Bit offset of a lane inside a packed multi-lane bus.
  function automatic int unsigned lane_lsb(int unsigned lane, int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/mac_lane_acc.sv
// One lane accumulator: zero-extended product add with wrap and carry-out.
module mac_lane_acc #(
  parameter int unsigned PROD_W = 16,
  parameter int unsigned ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc,
  output logic              carry
);

  logic [ACC_W:0] sum;

  always_comb begin
    sum   = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    carry = en & sum[ACC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/mac_array_sched.sv
// Job controller for the registered multiplier array: pulls K operand beats, accumulates the
// array products per lane, and presents the dot-product vector on a valid/ready output.
module mac_array_sched #(
  parameter int unsigned LANES  = mac_pkg::LANES,
  parameter int unsigned DATA_W = mac_pkg::DATA_W,
  parameter int unsigned PROD_W = mac_pkg::PROD_W,
  parameter int unsigned ACC_W  = mac_pkg::ACC_W,
  parameter int unsigned CNT_W  = mac_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          beats,
  output logic                      busy,
  output logic                      err_zero,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_a,
  input  logic [LANES*DATA_W-1:0]   in_b,
  output logic [LANES*DATA_W-1:0]   arr_a,
  output logic [LANES*DATA_W-1:0]   arr_b,
  input  logic [LANES*PROD_W-1:0]   arr_prod,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*ACC_W-1:0]    out_acc,
  output logic                      out_ovf
);

  import mac_pkg::*;

  state_e           state;
  logic [CNT_W-1:0] rem;
  logic             prod_vld;
  logic             fire;
  logic             job_clr;
  logic [LANES-1:0] carry;

  assign fire    = in_valid & in_ready;
  assign job_clr = (state == StIdle) & start & (beats != '0);

  // Operand buses idle at zero so the array sees no stray products between beats.
  always_comb begin
    arr_a = fire ? in_a : '0;
    arr_b = fire ? in_b : '0;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane_acc #(
      .PROD_W(PROD_W),
      .ACC_W (ACC_W)
    ) u_acc (
      .clk  (clk),
      .rst  (rst),
      .clr  (job_clr),
      .en   (prod_vld),
      .prod (arr_prod[lane_lsb(i, PROD_W) +: PROD_W]),
      .acc  (out_acc[lane_lsb(i, ACC_W) +: ACC_W]),
      .carry(carry[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      rem       <= '0;
      prod_vld  <= 1'b0;
      out_ovf   <= 1'b0;
      err_zero  <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      err_zero <= 1'b0;
      prod_vld <= fire;
      if (prod_vld && (carry != '0)) begin
        out_ovf <= 1'b1;
      end
      unique case (state)
        StIdle: begin
          if (start) begin
            if (beats == '0) begin
              err_zero <= 1'b1;
            end else begin
              rem      <= beats;
              out_ovf  <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              state    <= StRun;
            end
          end
        end
        StRun: begin
          if (fire) begin
            rem <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              in_ready <= 1'b0;
              state    <= StDrain;
            end
          end
        end
        // Last product lands on arr_prod this cycle and is folded in at the edge.
        StDrain: begin
          out_valid <= 1'b1;
          state     <= StHold;
        end
        StHold: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_array_sched.sv
// Self-checking bench: two controllers (24-bit and 17-bit accumulators) share one stimulus stream,
// each with its own registered multiplier array, checked against per-job dot-product sums.
module tb_mac_array_sched;

  localparam int L  = 8;
  localparam int DW = 8;
  localparam int PW = 16;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  logic [7:0] beats;
  logic [L*DW-1:0] in_a, in_b;

  logic busy24, err24, rdy24, ov24, ovf24;
  logic busy17, err17, rdy17, ov17, ovf17;
  logic [L*DW-1:0] arr_a24, arr_b24, arr_a17, arr_b17;
  logic [L*PW-1:0] prod24, prod17;
  logic [L*24-1:0] acc24;
  logic [L*17-1:0] acc17;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_array_sched u_dut24 (
    .clk(clk), .rst(rst), .start(start), .beats(beats), .busy(busy24), .err_zero(err24),
    .in_valid(in_valid), .in_ready(rdy24), .in_a(in_a), .in_b(in_b), .arr_a(arr_a24),
    .arr_b(arr_b24), .arr_prod(prod24), .out_valid(ov24), .out_ready(out_ready),
    .out_acc(acc24), .out_ovf(ovf24)
  );

  mac_array_sched #(.ACC_W(17)) u_dut17 (
    .clk(clk), .rst(rst), .start(start), .beats(beats), .busy(busy17), .err_zero(err17),
    .in_valid(in_valid), .in_ready(rdy17), .in_a(in_a), .in_b(in_b), .arr_a(arr_a17),
    .arr_b(arr_b17), .arr_prod(prod17), .out_valid(ov17), .out_ready(out_ready),
    .out_acc(acc17), .out_ovf(ovf17)
  );

  // Registered multiplier arrays, one per controller.
  always_ff @(posedge clk) begin
    for (int i = 0; i < L; i++) begin
      prod24[i*PW +: PW] <= arr_a24[i*DW +: DW] * arr_b24[i*DW +: DW];
      prod17[i*PW +: PW] <= arr_a17[i*DW +: DW] * arr_b17[i*DW +: DW];
    end
  end

  task automatic gen_ops(input int mode, output logic [L*DW-1:0] a, output logic [L*DW-1:0] b);
    for (int i = 0; i < L; i++) begin
      case (mode)
        1:       begin a[i*DW +: DW] = 8'd3;          b[i*DW +: DW] = 8'd5;          end
        2:       begin a[i*DW +: DW] = 8'(i + 1);     b[i*DW +: DW] = 8'd2;          end
        3:       begin a[i*DW +: DW] = 8'd255;        b[i*DW +: DW] = 8'd255;        end
        4:       begin a[i*DW +: DW] = 8'd1;          b[i*DW +: DW] = 8'd1;          end
        5:       begin a[i*DW +: DW] = 8'd2;          b[i*DW +: DW] = 8'd2;          end
        default: begin a[i*DW +: DW] = 8'($urandom); b[i*DW +: DW] = 8'($urandom); end
      endcase
    end
  endtask

  task automatic run_job(input int n, input int mode, input int gap_at, input int gap_len,
                         input bit rand_gaps, input int hold, input string tag);
    longint unsigned sum [L];
    logic [L*24-1:0] e24;
    logic [L*17-1:0] e17;
    logic o24, o17;
    logic [L*DW-1:0] a, b;
    int fired, rgaps, fgaps;
    bit bubble;
    for (int i = 0; i < L; i++) sum[i] = 0;
    @(negedge clk);
    start = 1'b1; beats = 8'(n); in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy24, busy17} !== 2'b11) begin
      n_bad++; $display("FAIL %s busy_run: got %b expected 11", tag, {busy24, busy17});
    end
    fired = 0; rgaps = 0; fgaps = 0;
    while (fired < n) begin
      bubble = 1'b0;
      if (rand_gaps && rgaps < n + 4 && $urandom_range(2) == 0) begin
        bubble = 1'b1; rgaps++;
      end
      if (fired == gap_at && fgaps < gap_len) begin
        bubble = 1'b1; fgaps++;
      end
      gen_ops(mode, a, b);
      in_a = a; in_b = b; in_valid = !bubble;
      #1;
      n_cmp++;
      if ({rdy24, rdy17} !== 2'b11) begin
        n_bad++; $display("FAIL %s in_ready_run: got %b expected 11", tag, {rdy24, rdy17});
      end
      n_cmp++;
      if (bubble) begin
        if ({arr_a24, arr_b24, arr_a17, arr_b17} !== '0) begin
          n_bad++; $display("FAIL %s arr_bubble: got %h/%h expected 0", tag, arr_a24, arr_a17);
        end
      end else begin
        if ({arr_a24, arr_b24, arr_a17, arr_b17} !== {a, b, a, b}) begin
          n_bad++; $display("FAIL %s arr_fire: got %h %h expected %h %h", tag, arr_a24, arr_b24, a, b);
        end
        for (int i = 0; i < L; i++) sum[i] += a[i*DW +: DW] * b[i*DW +: DW];
        fired++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    n_cmp++;
    if ({rdy24, rdy17, ov24, ov17} !== 4'b0000) begin
      n_bad++;
      $display("FAIL %s drain_cycle: got rdy/valid %b expected 0000", tag, {rdy24, rdy17, ov24, ov17});
    end
    @(negedge clk);
    o24 = 1'b0; o17 = 1'b0;
    for (int i = 0; i < L; i++) begin
      e24[i*24 +: 24] = sum[i][23:0];
      e17[i*17 +: 17] = sum[i][16:0];
      if (sum[i] >= 64'd16777216) o24 = 1'b1;
      if (sum[i] >= 64'd131072)   o17 = 1'b1;
    end
    n_cmp++;
    if ({ov24, ov17} !== 2'b11) begin
      n_bad++; $display("FAIL %s out_valid_latency: got %b expected 11", tag, {ov24, ov17});
    end
    n_cmp++;
    if (acc24 !== e24) begin
      n_bad++; $display("FAIL %s acc24: got %h expected %h", tag, acc24, e24);
    end
    n_cmp++;
    if (acc17 !== e17) begin
      n_bad++; $display("FAIL %s acc17: got %h expected %h", tag, acc17, e17);
    end
    n_cmp++;
    if ({ovf24, ovf17} !== {o24, o17}) begin
      n_bad++; $display("FAIL %s ovf: got %b expected %b", tag, {ovf24, ovf17}, {o24, o17});
    end
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0; start = 1'b1;
      beats = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      @(negedge clk);
      n_cmp++;
      if ({ov24, ov17, busy24, busy17, err24, err17} !== 6'b111100 ||
          acc24 !== e24 || acc17 !== e17) begin
        n_bad++;
        $display("FAIL %s hold_stable: got v/b/e %b acc %h expected 111100 acc %h", tag,
                 {ov24, ov17, busy24, busy17, err24, err17}, acc24, e24);
      end
    end
    start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({busy24, busy17, ov24, ov17, rdy24, rdy17} !== 6'b0 || acc24 !== e24 || acc17 !== e17) begin
      n_bad++;
      $display("FAIL %s release: got b/v/r %b acc %h expected 000000 acc %h", tag,
               {busy24, busy17, ov24, ov17, rdy24, rdy17}, acc24, e24);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy24, busy17, err24, err17, rdy24, rdy17, ov24, ov17, ovf24, ovf17} !== 10'b0 ||
        acc24 !== '0 || acc17 !== '0 || {arr_a24, arr_b24, arr_a17, arr_b17} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got flags %b acc %h expected 0",
               {busy24, busy17, err24, err17, rdy24, rdy17, ov24, ov17, ovf24, ovf17}, acc24);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    logic [L*DW-1:0] a, b;
    @(negedge clk);
    start = 1'b1; beats = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      gen_ops(0, a, b);
      in_a = a; in_b = b; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy24, busy17, ov24, ov17, rdy24, rdy17, ovf24, ovf17} !== 8'b0 ||
        acc24 !== '0 || acc17 !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_job: got flags %b acc %h expected 0",
               {busy24, busy17, ov24, ov17, rdy24, rdy17, ovf24, ovf17}, acc24);
    end
    run_job(1, 5, -1, 0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_err_zero();
    @(negedge clk);
    start = 1'b1; beats = 8'd0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({err24, err17, busy24, busy17, rdy24, rdy17} !== 6'b110000) begin
      n_bad++;
      $display("FAIL err_zero_pulse: got e/b/r %b expected 110000", {err24, err17, busy24, busy17, rdy24, rdy17});
    end
    @(negedge clk);
    n_cmp++;
    if ({err24, err17, busy24, busy17, rdy24, rdy17} !== 6'b0) begin
      n_bad++;
      $display("FAIL err_zero_clear: got e/b/r %b expected 000000", {err24, err17, busy24, busy17, rdy24, rdy17});
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 10; j++) begin
      run_job($urandom_range(12, 1), 0, -1, 0, 1'b1, $urandom_range(3), "random");
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; beats = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    test_reset();
    run_job(1, 1, -1, 0, 1'b0, 0, "single_beat");
    run_job(4, 2, 2, 2, 1'b0, 0, "bubbles");
    run_job(3, 3, -1, 0, 1'b0, 0, "overflow");
    run_job(1, 4, -1, 0, 1'b0, 0, "ovf_cleared");
    run_job(2, 0, -1, 0, 1'b0, 5, "hold");
    test_reset_mid_job();
    test_err_zero();
    test_random();
    run_job(255, 3, -1, 0, 1'b0, 1, "max_beats");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
